// File: rtl/conf_pkg.sv
// Shared definitions for the configuration word layout used by conf_encoder and decoder.
// conf_pack is the single source of truth for where each field sits in the word.
package conf_pkg;

    localparam int CONF_WORD_W = 15;

    localparam int OFFSET_LSB = 0;
    localparam int ORDER_LSB  = 3;
    localparam int CYCLE_LSB  = 6;
    localparam int RET_BIT    = 14;

    localparam int OFFSET_W = 3;
    localparam int ORDER_W  = 3;
    localparam int CYCLE_W  = 8;
    localparam int RET_W    = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } conf_state_t;

    function automatic logic [CONF_WORD_W-1:0] conf_pack(
        input logic [OFFSET_W-1:0] offset,
        input logic [ORDER_W-1:0]  order,
        input logic [CYCLE_W-1:0]  cycle,
        input logic                ret
    );
        logic [CONF_WORD_W-1:0] w;
        w = '0;
        w[OFFSET_LSB +: OFFSET_W] = offset;
        w[ORDER_LSB +: ORDER_W]   = order;
        w[CYCLE_LSB +: CYCLE_W]   = cycle;
        w[RET_BIT +: RET_W]       = ret;
        return w;
    endfunction

endpackage

// File: rtl/conf_encoder.sv
// Writes a stream of configuration entries as packed words to the configuration BRAM,
// starting at address 0, and enables the decoder once the whole program is resident.
module conf_encoder
    import conf_pkg::*;
#(
    parameter int CONF_DATA_WIDTH = 15,
    parameter int CONF_ADDR_WIDTH = 9,
    parameter int RAMB36_WIDTH    = 72
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_start,
    input  logic                       ent_vld,
    output logic                       ent_rdy,
    input  logic [2:0]                 ent_offset,
    input  logic [2:0]                 ent_order,
    input  logic [7:0]                 ent_cycle,
    input  logic                       ent_last,
    output logic                       conf_bram_wr_en,
    output logic [CONF_ADDR_WIDTH-1:0] conf_bram_wr_addr,
    output logic [RAMB36_WIDTH-1:0]    conf_bram_wr_data,
    output logic                       prog_done,
    output logic [CONF_ADDR_WIDTH:0]   prog_len,
    output logic                       prog_err,
    output logic                       decoder_en
);

    conf_state_t                state;
    logic [CONF_ADDR_WIDTH:0]   wr_cnt;
    logic                       hs;
    logic                       at_top;
    logic                       ret;
    logic [RAMB36_WIDTH-1:0]    data_p0;

    logic                       wr_vld_p1;
    logic [CONF_ADDR_WIDTH-1:0] wr_addr_p1;
    logic [RAMB36_WIDTH-1:0]    wr_data_p1;

    // Entries are refused while prog_start is high so a restart never races a write.
    assign ent_rdy = (state == LOAD) && !prog_start;
    assign hs      = ent_vld && ent_rdy;
    assign at_top  = (wr_cnt[CONF_ADDR_WIDTH-1:0] == {CONF_ADDR_WIDTH{1'b1}});
    assign ret     = ent_last || at_top;

    // p0: pack the accepted entry; the last BRAM slot always terminates the program
    always_comb begin
        data_p0 = '0;
        data_p0[CONF_DATA_WIDTH-1:0] =
            CONF_DATA_WIDTH'(conf_pack(ent_offset, ent_order, ent_cycle, ret));
    end

    // p1: registered BRAM write port plus program-control FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            prog_done  <= 1'b0;
            prog_len   <= '0;
            prog_err   <= 1'b0;
            decoder_en <= 1'b0;
        end else begin
            wr_vld_p1 <= hs;
            prog_done <= 1'b0;
            if (hs) begin
                wr_addr_p1 <= wr_cnt[CONF_ADDR_WIDTH-1:0];
                wr_data_p1 <= data_p0;
            end
            if (prog_start) begin
                state      <= LOAD;
                wr_cnt     <= '0;
                prog_err   <= 1'b0;
                decoder_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    LOAD: begin
                        if (hs) begin
                            wr_cnt <= wr_cnt + 1'b1;
                            if (ret)
                                state <= DONE;
                            if (at_top && !ent_last)
                                prog_err <= 1'b1;
                        end
                    end
                    DONE: begin
                        // Last word is already in the BRAM by now, so the decoder may start.
                        prog_done  <= 1'b1;
                        decoder_en <= 1'b1;
                        prog_len   <= wr_cnt;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign conf_bram_wr_en   = wr_vld_p1;
    assign conf_bram_wr_addr = wr_addr_p1;
    assign conf_bram_wr_data = wr_data_p1;

endmodule

// File: tb/tb_conf_encoder.sv
// Directed bench for conf_encoder: a scoreboard queue holds expected BRAM writes,
// filled when an entry is offered to a ready DUT and drained as writes appear.
module tb_conf_encoder;

    localparam int AW = 9;
    localparam int DW = 72;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_start;
    logic          ent_vld;
    logic          ent_rdy;
    logic [2:0]    ent_offset;
    logic [2:0]    ent_order;
    logic [7:0]    ent_cycle;
    logic          ent_last;
    logic          conf_bram_wr_en;
    logic [AW-1:0] conf_bram_wr_addr;
    logic [DW-1:0] conf_bram_wr_data;
    logic          prog_done;
    logic [AW:0]   prog_len;
    logic          prog_err;
    logic          decoder_en;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            checks = 0;
    int            failures = 0;
    logic          m_load = 1'b0;
    int            m_cnt = 0;
    int            done_cnt = 0;
    int            wr_seen = 0;
    logic [DW-1:0] last_data = '0;

    conf_encoder dut (
        .clk               (clk),
        .rst               (rst),
        .prog_start        (prog_start),
        .ent_vld           (ent_vld),
        .ent_rdy           (ent_rdy),
        .ent_offset        (ent_offset),
        .ent_order         (ent_order),
        .ent_cycle         (ent_cycle),
        .ent_last          (ent_last),
        .conf_bram_wr_en   (conf_bram_wr_en),
        .conf_bram_wr_addr (conf_bram_wr_addr),
        .conf_bram_wr_data (conf_bram_wr_data),
        .prog_done         (prog_done),
        .prog_len          (prog_len),
        .prog_err          (prog_err),
        .decoder_en        (decoder_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] ref_word(input int off, input int ord, input int cyc, input int ret);
        return DW'(off + ord * 8 + cyc * 64 + ret * 16384);
    endfunction

    // One clock: predict readiness/handshake, clock, then score any write.
    task automatic step();
        wr_t  e;
        logic hs;
        #1;
        chk("ent_rdy", DW'(ent_rdy), DW'(m_load && !prog_start));
        hs = ent_vld && m_load && !prog_start;
        if (prog_start) begin
            m_load = 1'b1;
            m_cnt  = 0;
        end else if (hs) begin
            e.addr = AW'(m_cnt);
            e.data = ref_word(int'(ent_offset), int'(ent_order), int'(ent_cycle),
                              (ent_last || m_cnt == 511) ? 1 : 0);
            exp_q.push_back(e);
            m_cnt++;
            if (ent_last || m_cnt == 512)
                m_load = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("wr_en", DW'(conf_bram_wr_en), DW'(hs));
        if (conf_bram_wr_en === 1'b1) begin
            wr_seen++;
            last_data = conf_bram_wr_data;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", DW'(conf_bram_wr_addr), DW'(e.addr));
                chk("wr_data", conf_bram_wr_data, e.data);
            end
        end
        if (prog_done === 1'b1)
            done_cnt++;
    endtask

    task automatic idle(input int n);
        ent_vld    = 1'b0;
        prog_start = 1'b0;
        repeat (n) step();
    endtask

    task automatic start();
        prog_start = 1'b1;
        ent_vld    = 1'b0;
        step();
        prog_start = 1'b0;
    endtask

    task automatic send(input int off, input int ord, input int cyc, input logic last);
        ent_offset = 3'(off);
        ent_order  = 3'(ord);
        ent_cycle  = 8'(cyc);
        ent_last   = last;
        ent_vld    = 1'b1;
        step();
        ent_vld    = 1'b0;
    endtask

    int tbl[3][4] = '{'{1, 2, 5, 0}, '{7, 4, 255, 0}, '{0, 1, 0, 1}};

    initial begin
        rst        = 1'b1;
        prog_start = 1'b0;
        ent_vld    = 1'b0;
        ent_offset = '0;
        ent_order  = '0;
        ent_cycle  = '0;
        ent_last   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", DW'(conf_bram_wr_en), DW'(0));
        chk("rst_wr_addr", DW'(conf_bram_wr_addr), DW'(0));
        chk("rst_wr_data", conf_bram_wr_data, DW'(0));
        chk("rst_done", DW'(prog_done), DW'(0));
        chk("rst_len", DW'(prog_len), DW'(0));
        chk("rst_err", DW'(prog_err), DW'(0));
        chk("rst_dec_en", DW'(decoder_en), DW'(0));
        chk("rst_rdy", DW'(ent_rdy), DW'(0));
        rst = 1'b0;

        // Entries offered in IDLE must be ignored
        ent_offset = 3'd3; ent_order = 3'd3; ent_cycle = 8'd9; ent_vld = 1'b1;
        step();
        step();
        ent_vld = 1'b0;

        // Back-to-back program
        start();
        chk("p1_dec_en_low", DW'(decoder_en), DW'(0));
        done_cnt = 0;
        for (int i = 0; i < 3; i++)
            send(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3][0]);
        chk("p1_last_word", last_data, 72'h4008);
        chk("p1_done_early", DW'(prog_done), DW'(0));
        idle(1);
        chk("p1_done", DW'(prog_done), DW'(1));
        chk("p1_len", DW'(prog_len), DW'(3));
        chk("p1_dec_en", DW'(decoder_en), DW'(1));
        chk("p1_err", DW'(prog_err), DW'(0));
        idle(3);
        chk("p1_done_pulses", DW'(done_cnt), DW'(1));

        // Same entries with random gaps
        start();
        done_cnt = 0;
        wr_seen  = 0;
        for (int i = 0; i < 3; i++) begin
            idle(int'($urandom_range(0, 3)));
            send(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3][0]);
        end
        idle(4);
        chk("gap_writes", DW'(wr_seen), DW'(3));
        chk("gap_done_pulses", DW'(done_cnt), DW'(1));
        chk("gap_len", DW'(prog_len), DW'(3));

        // Restart mid-program with an entry offered in the same cycle
        start();
        done_cnt = 0;
        send(2, 2, 2, 1'b0);
        send(4, 4, 4, 1'b0);
        ent_offset = 3'd6; ent_order = 3'd5; ent_cycle = 8'd77; ent_last = 1'b0;
        ent_vld    = 1'b1;
        prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        chk("rs_dec_en", DW'(decoder_en), DW'(0));
        step();
        ent_vld = 1'b0;
        chk("rs_addr0", DW'(conf_bram_wr_addr), DW'(0));
        idle(2);
        chk("rs_no_done", DW'(done_cnt), DW'(0));

        // Overflow: 512 entries, none marked last
        start();
        done_cnt = 0;
        wr_seen  = 0;
        for (int i = 0; i < 512; i++)
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)), 1'b0);
        chk("ov_writes", DW'(wr_seen), DW'(512));
        chk("ov_ret_bit", DW'(last_data[14]), DW'(1));
        idle(1);
        chk("ov_done", DW'(prog_done), DW'(1));
        chk("ov_len", DW'(prog_len), DW'(512));
        chk("ov_err", DW'(prog_err), DW'(1));
        chk("ov_dec_en", DW'(decoder_en), DW'(1));
        send(1, 1, 1, 1'b0);
        idle(2);
        chk("ov_done_pulses", DW'(done_cnt), DW'(1));

        // Second program clears the error and holds the old length until done
        start();
        chk("p2_err_clr", DW'(prog_err), DW'(0));
        chk("p2_dec_en_low", DW'(decoder_en), DW'(0));
        chk("p2_len_hold", DW'(prog_len), DW'(512));
        done_cnt = 0;
        send(5, 6, 0, 1'b1);
        chk("p2_word", last_data, 72'h4035);
        idle(1);
        chk("p2_done", DW'(prog_done), DW'(1));
        chk("p2_len", DW'(prog_len), DW'(1));
        chk("p2_dec_en", DW'(decoder_en), DW'(1));

        // Asynchronous reset in the middle of a program
        start();
        send(3, 1, 4, 1'b0);
        ent_vld = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mr_wr_en", DW'(conf_bram_wr_en), DW'(0));
        chk("mr_wr_data", conf_bram_wr_data, DW'(0));
        chk("mr_len", DW'(prog_len), DW'(0));
        chk("mr_rdy", DW'(ent_rdy), DW'(0));
        chk("mr_done", DW'(prog_done), DW'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_load = 1'b0;
        exp_q.delete();
        step();
        step();
        ent_vld = 1'b0;
        chk("mr_dec_en", DW'(decoder_en), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
